// File: rtl/iq_issue_select.sv
// Issue side of a 16-entry centralized issue queue: dispatch write, tag wakeup,
// oldest-ready selection and valid/ready issue handshake.
module iq_issue_select #(
  parameter int unsigned OPCODE    = 7,
  parameter int unsigned PRF_WIDTH = 6,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [OPCODE-1:0]    disp_op,
  input  logic [PRF_WIDTH-1:0] disp_prs1,
  input  logic [PRF_WIDTH-1:0] disp_prs2,
  input  logic                 disp_prs1_v,
  input  logic                 disp_prs2_v,
  input  logic                 disp_prs1_rdy,
  input  logic                 disp_prs2_rdy,
  input  logic [PRF_WIDTH-1:0] disp_prd,
  input  logic                 disp_prd_v,
  input  logic                 wb0_valid,
  input  logic [PRF_WIDTH-1:0] wb0_prd,
  input  logic                 wb1_valid,
  input  logic [PRF_WIDTH-1:0] wb1_prd,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [OPCODE-1:0]    iss_op,
  output logic [PRF_WIDTH-1:0] iss_prs1,
  output logic [PRF_WIDTH-1:0] iss_prs2,
  output logic [PRF_WIDTH-1:0] iss_prd,
  output logic                 iss_prs1_v,
  output logic                 iss_prs2_v,
  output logic                 iss_prd_v,
  output logic [3:0]           iss_idx,
  output logic [4:0]           count
);

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     prs1_v_q, prs1_v_d, prs2_v_q, prs2_v_d, prd_v_q, prd_v_d;
  logic [DEPTH-1:0]     rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [OPCODE-1:0]    op_q   [DEPTH];
  logic [OPCODE-1:0]    op_d   [DEPTH];
  logic [PRF_WIDTH-1:0] prs1_q [DEPTH];
  logic [PRF_WIDTH-1:0] prs1_d [DEPTH];
  logic [PRF_WIDTH-1:0] prs2_q [DEPTH];
  logic [PRF_WIDTH-1:0] prs2_d [DEPTH];
  logic [PRF_WIDTH-1:0] prd_q  [DEPTH];
  logic [PRF_WIDTH-1:0] prd_d  [DEPTH];
  logic [3:0]           age_q  [DEPTH];
  logic [3:0]           age_d  [DEPTH];
  logic [4:0]           count_q, count_d;

  logic [DEPTH-1:0] issuable;
  logic             sel_found;
  logic [3:0]       sel_idx;
  logic [3:0]       sel_age;
  logic             free_found;
  logic [3:0]       free_idx;
  logic             disp_fire;
  logic             iss_fire;
  logic [3:0]       disp_age;

  function automatic logic wake(input logic [PRF_WIDTH-1:0] tag,
                                input logic                 v0,
                                input logic [PRF_WIDTH-1:0] t0,
                                input logic                 v1,
                                input logic [PRF_WIDTH-1:0] t1);
    return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
  endfunction

  // Ages are unique among valid entries, so the minimum-age issuable entry is unique.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      issuable[i] = valid_q[i] && (!prs1_v_q[i] || rdy1_q[i]) && (!prs2_v_q[i] || rdy2_q[i]);
      if (issuable[i] && (!sel_found || (age_q[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = 4'(i);
        sel_age   = age_q[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end
  end

  assign count      = count_q;
  assign disp_ready = (count_q < 5'd16);
  assign iss_valid  = sel_found;
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_fire   = sel_found && iss_ready;
  assign disp_age   = iss_fire ? 4'(count_q - 5'd1) : count_q[3:0];

  // Data outputs are forced to zero when nothing is offered so reset values are clean.
  always_comb begin
    iss_idx    = sel_idx;
    iss_op     = '0;
    iss_prs1   = '0;
    iss_prs2   = '0;
    iss_prd    = '0;
    iss_prs1_v = 1'b0;
    iss_prs2_v = 1'b0;
    iss_prd_v  = 1'b0;
    if (sel_found) begin
      iss_op     = op_q[sel_idx];
      iss_prs1   = prs1_q[sel_idx];
      iss_prs2   = prs2_q[sel_idx];
      iss_prd    = prd_q[sel_idx];
      iss_prs1_v = prs1_v_q[sel_idx];
      iss_prs2_v = prs2_v_q[sel_idx];
      iss_prd_v  = prd_v_q[sel_idx];
    end
  end

  always_comb begin
    valid_d  = valid_q;
    prs1_v_d = prs1_v_q;
    prs2_v_d = prs2_v_q;
    prd_v_d  = prd_v_q;
    rdy1_d   = rdy1_q;
    rdy2_d   = rdy2_q;
    op_d     = op_q;
    prs1_d   = prs1_q;
    prs2_d   = prs2_q;
    prd_d    = prd_q;
    age_d    = age_q;
    count_d  = count_q + 5'(disp_fire) - 5'(iss_fire);

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (wake(prs1_q[i], wb0_valid, wb0_prd, wb1_valid, wb1_prd)) rdy1_d[i] = 1'b1;
        if (wake(prs2_q[i], wb0_valid, wb0_prd, wb1_valid, wb1_prd)) rdy2_d[i] = 1'b1;
        if (iss_fire && (age_q[i] > sel_age)) age_d[i] = age_q[i] - 4'd1;
      end
    end

    if (iss_fire) valid_d[sel_idx] = 1'b0;

    // Free slot comes from registered state, so a slot freed this cycle is not reused yet.
    if (disp_fire) begin
      valid_d[free_idx]  = 1'b1;
      op_d[free_idx]     = disp_op;
      prs1_d[free_idx]   = disp_prs1;
      prs2_d[free_idx]   = disp_prs2;
      prd_d[free_idx]    = disp_prd;
      prs1_v_d[free_idx] = disp_prs1_v;
      prs2_v_d[free_idx] = disp_prs2_v;
      prd_v_d[free_idx]  = disp_prd_v;
      rdy1_d[free_idx]   = disp_prs1_rdy ||
                           wake(disp_prs1, wb0_valid, wb0_prd, wb1_valid, wb1_prd);
      rdy2_d[free_idx]   = disp_prs2_rdy ||
                           wake(disp_prs2, wb0_valid, wb0_prd, wb1_valid, wb1_prd);
      age_d[free_idx]    = disp_age;
    end

    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      prs1_v_q <= '0;
      prs2_v_q <= '0;
      prd_v_q  <= '0;
      rdy1_q   <= '0;
      rdy2_q   <= '0;
      op_q     <= '{default: '0};
      prs1_q   <= '{default: '0};
      prs2_q   <= '{default: '0};
      prd_q    <= '{default: '0};
      age_q    <= '{default: '0};
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      prs1_v_q <= prs1_v_d;
      prs2_v_q <= prs2_v_d;
      prd_v_q  <= prd_v_d;
      rdy1_q   <= rdy1_d;
      rdy2_q   <= rdy2_d;
      op_q     <= op_d;
      prs1_q   <= prs1_d;
      prs2_q   <= prs2_d;
      prd_q    <= prd_d;
      age_q    <= age_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/iq_issue_select.md
# iq_issue_select

Issue side of the centralized 16-entry issue queue. Entries are written from rename/dispatch through a single valid/ready dispatch port. The block tracks operand readiness from two writeback tag broadcasts and selects the oldest fully-ready entry each cycle. It hands that entry to the execute stage over a valid/ready issue port and frees the slot on acceptance, which makes it the reader for the queue that dispatch writes.

## Interface
- OPCODE, 7, opcode width
- PRF_WIDTH, 6, physical register tag width
- DEPTH, 16, queue entries (fixed at 16; index width 4)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous: invalidate every entry
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept (count < 16)
- disp_op  in  OPCODE  opcode
- disp_prs1 / disp_prs2  in  PRF_WIDTH  source tags
- disp_prs1_v / disp_prs2_v  in  1  source present
- disp_prs1_rdy / disp_prs2_rdy  in  1  source already ready at rename
- disp_prd  in  PRF_WIDTH  destination tag
- disp_prd_v  in  1  destination present
- wb0_valid, wb1_valid  in  1  wakeup broadcast valid
- wb0_prd, wb1_prd  in  PRF_WIDTH  broadcast tag
- iss_valid  out  1  a ready entry is offered
- iss_ready  in  1  execute accepts
- iss_op  out  OPCODE  selected opcode
- iss_prs1, iss_prs2, iss_prd  out  PRF_WIDTH  selected tags
- iss_prs1_v, iss_prs2_v, iss_prd_v  out  1  selected presence bits
- iss_idx  out  4  selected entry index
- count  out  5  number of valid entries (0..16)

## Operation
- Per entry: valid, op, prs1/prs2/prd plus their _v bits, rdy1, rdy2, age[3:0].
- Ready rule: entry is issuable iff valid && (!prs1_v || rdy1) && (!prs2_v || rdy2).
- Age encodes rank: age = number of valid entries older than this one. Ages are unique among valid entries, and the oldest entry has age 0.
- Select: the issuable entry with minimum age. It is driven combinationally from registered state onto iss_*, and iss_valid = any issuable entry.
- Issue handshake: when iss_valid && iss_ready, the selected entry's valid is cleared at the edge. Every valid entry with age > selected age decrements its age by 1.
- Dispatch handshake: when disp_valid && disp_ready, the lowest-index free slot is written with valid=1. Its age is set to count minus 1 if an issue fires in the same cycle, otherwise to count.
- Wakeup: for each valid entry and each wbN_valid, if prs1 == wbN_prd then rdy1 is set, and the same applies to prs2/rdy2. Bits are set-only and stay set until the entry is freed.
- Dispatch bypass: the written rdy bit = disp_prsX_rdy OR a match against either wb tag in the same cycle.
- count: +1 on dispatch, −1 on issue, unchanged when both fire.
- flush: clears all valid bits and sets count to 0. It takes priority over same-cycle dispatch and issue, so neither takes effect.
- Unused fields of invalid entries are don't-care. iss_* data is don't-care when iss_valid=0.

## Timing
- Reset (rst_n low, asynchronous) drives the following values:
  - all valid bits = 0 and count = 0
  - iss_valid = 0, iss_idx = 0, all iss_* = 0
  - disp_ready = 1
- Dispatch-to-issue latency: an entry dispatched at edge N with both sources ready can be offered in cycle N+1. Earliest acceptance is edge N+1.
- Wakeup-to-issue latency: a broadcast in cycle N sets rdy at edge N. The entry can be selected in cycle N+1.
- disp_ready depends only on registered count (count < 16), never on iss_ready. A full queue with a same-cycle issue still refuses dispatch.
- Selection is recomputed every cycle, and there is no hold requirement while iss_ready=0. A newly woken older entry may replace the offered one. The execute stage samples iss_* only at a handshake.
- One issue and one dispatch per cycle at most.
- Freed slots are reusable by a dispatch in the following cycle.

## Test plan
- Reset, then dispatch 3 entries with all sources ready and iss_ready=0.
  - Required: count=3, iss_valid=1, iss_idx=0, ages 0,1,2.
  - Then raise iss_ready for 3 cycles: issue order is idx 0,1,2 and count returns to 0.
- Dispatch A (prs1=5, prs1_v=1, not ready), then B (all ready).
  - Required: B issues first.
  - Then pulse wb1_valid with wb1_prd=5: A is offered the next cycle.
- Dispatch in the same cycle as wb0_prd=9, with disp_prs2=9, disp_prs2_v=1, disp_prs2_rdy=0.
  - Required: the entry is issuable the next cycle.
- Fill to 16 entries.
  - Required: disp_ready=0.
  - Issue one: disp_ready=1 next cycle. The new dispatch lands in the freed index with age 15.
- With 2 entries and iss_ready=1, assert disp_valid in the same cycle.
  - Required: count stays 2, ages stay unique (0,1), and the new entry has age 1.
- Assert flush with 5 entries while dispatch and issue are also active.
  - Required: count=0, iss_valid=0 next cycle.
  - Assert rst_n low mid-operation: outputs go to reset values immediately.
